// File: rtl/meb_dbus.sv
// Memory-stage data-bus master: turns load/store ops into single bus transactions,
// big-endian lane steering, load extension, misalignment traps and flush draining.
module meb_dbus (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  meb_alu_op,
  input  logic [31:0] meb_meb_add,
  input  logic [31:0] meb_reg2,
  input  logic        meb_w_reg,
  input  logic [4:0]  meb_w_add,
  input  logic [31:0] meb_w_data,
  input  logic        flush,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic        stallreq,
  output logic        wb_w_reg,
  output logic [4:0]  wb_w_add,
  output logic [31:0] wb_w_data,
  output logic        adel,
  output logic        ades
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_op;
  logic [1:0]  r_off;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_issue;
  logic        w_ack_load;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;

  // Big-endian lane select: byte offset 0 lives on bits 31:24.
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_LB, OP_LBU, OP_SB: s = 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: s = off[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         s = 4'b1111;
      default:              s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] src);
    logic [31:0] d;
    d = 32'h0;
    case (op)
      OP_SB:   d = {4{src[7:0]}};
      OP_SH:   d = {2{src[15:0]}};
      OP_SW:   d = src;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    b = 8'h0;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   d = {{24{b[7]}}, b};
      OP_LBU:  d = {24'h0, b};
      OP_LH:   d = {{16{h[15]}}, h};
      OP_LHU:  d = {16'h0, h};
      default: d = rd;
    endcase
    return d;
  endfunction

  assign w_is_load  = (meb_alu_op == OP_LB) || (meb_alu_op == OP_LBU) ||
                      (meb_alu_op == OP_LH) || (meb_alu_op == OP_LHU) ||
                      (meb_alu_op == OP_LW);
  assign w_is_store = (meb_alu_op == OP_SB) || (meb_alu_op == OP_SH) ||
                      (meb_alu_op == OP_SW);
  assign w_is_half  = (meb_alu_op == OP_LH) || (meb_alu_op == OP_LHU) ||
                      (meb_alu_op == OP_SH);
  assign w_is_word  = (meb_alu_op == OP_LW) || (meb_alu_op == OP_SW);
  assign w_mem_op   = w_is_load || w_is_store;
  assign w_misalign = (w_is_half && meb_meb_add[0]) || (w_is_word && (meb_meb_add[1:0] != 2'b00));
  assign w_issue    = (r_state == S_IDLE) && w_mem_op && !w_misalign && !flush;
  assign w_ack_load = (r_state == S_BUSY) && dbus_ack && !flush && !r_we;
  assign w_sel      = lane_sel(meb_alu_op, meb_meb_add[1:0]);
  assign w_wdata    = store_data(meb_alu_op, meb_reg2);

  // State and captured load value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load_data <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ack_load)
        r_load_data <= load_ext(r_op, r_off, dbus_rdata);
    end
  end

  // Bus fields latched at issue so they stay put while the request is outstanding.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_op    <= meb_alu_op;
      r_off   <= meb_meb_add[1:0];
      r_we    <= w_is_store;
      r_sel   <= w_sel;
      r_addr  <= {meb_meb_add[31:2], 2'b00};
      r_wdata <= w_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush)         w_state_nxt = dbus_ack ? S_IDLE : S_DRAIN;
        else if (dbus_ack) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_DRAIN: if (dbus_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_sel   = 4'b0000;
    dbus_addr  = 32'h0;
    dbus_wdata = 32'h0;
    stallreq   = 1'b0;
    wb_w_reg   = 1'b0;
    wb_w_add   = 5'h0;
    wb_w_data  = 32'h0;
    adel       = 1'b0;
    ades       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          wb_w_add  = meb_w_add;
          wb_w_data = meb_w_data;
          wb_w_reg  = meb_w_reg && !flush && !w_mem_op;
          adel      = w_is_load && w_misalign;
          ades      = w_is_store && w_misalign;
          if (w_issue) begin
            dbus_req   = 1'b1;
            dbus_we    = w_is_store;
            dbus_sel   = w_sel;
            dbus_addr  = {meb_meb_add[31:2], 2'b00};
            dbus_wdata = w_wdata;
            stallreq   = 1'b1;
          end
        end
        S_BUSY, S_DRAIN: begin
          dbus_req   = 1'b1;
          dbus_we    = r_we;
          dbus_sel   = r_sel;
          dbus_addr  = r_addr;
          dbus_wdata = r_wdata;
          stallreq   = 1'b1;
          wb_w_add   = meb_w_add;
          wb_w_data  = meb_w_data;
        end
        S_DONE: begin
          wb_w_reg  = meb_w_reg && !flush;
          wb_w_add  = meb_w_add;
          wb_w_data = r_we ? meb_w_data : r_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
